// File: rtl/qround.sv
// qround: drops NBITS LSBs with truncate / half-up / half-even rounding, saturating or
// wrapping on overflow, behind a registered valid/ready stage. Define QROUND_SKID_EN for a skid entry.
module qround #(
   parameter int DIN    = 16,
   parameter int NBITS  = 4,
   parameter int MODE   = 0,
   parameter int SIGNED = 0,
   parameter int SAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_din_valid,
   output logic                  o_din_ready,
   input  logic [DIN-1:0]        i_din_data,
   output logic                  o_dout_valid,
   input  logic                  i_dout_ready,
   output logic [DIN-NBITS-1:0]  o_dout_data,
   output logic                  o_ovf
);

   localparam int DOUT = DIN - NBITS;
   localparam logic [DOUT-1:0] HI_ONES = '1;
   localparam logic [DOUT-1:0] HI_MAX  = (SIGNED != 0) ? (HI_ONES >> 1) : HI_ONES;
   localparam logic [DIN:0]    ONE_X   = (DIN+1)'(1);
   // Input is shifted up by one so the guard bit and sticky mask stay in range for NBITS of 0 or 1.
   localparam logic [DIN:0]    SMASK   = ((ONE_X << NBITS) - ONE_X) & ~ONE_X;

   function automatic logic [DOUT:0] quantise(input logic [DIN-1:0] d);
      logic [DIN:0]    ext;
      logic [DOUT-1:0] hi;
      logic            g;
      logic            s;
      logic            inc;
      logic            o;
      logic [DOUT:0]   sum;
      logic [DOUT-1:0] res;
      ext = {d, 1'b0};
      hi  = DOUT'(d >> NBITS);
      g   = ext[NBITS];
      s   = |(ext & SMASK);
      case (MODE)
         1:       inc = g;
         2:       inc = g & (s | hi[0]);
         default: inc = 1'b0;
      endcase
      sum = {1'b0, hi} + {{DOUT{1'b0}}, inc};
      o   = inc & (hi == HI_MAX);
      res = (o && (SAT != 0)) ? hi : sum[DOUT-1:0];
      return {o, res};
   endfunction

   logic [DOUT:0]   w_q_p0;
   logic [DOUT-1:0] w_data_p0;
   logic            w_ovf_p0;
   logic            w_acc;
   logic            r_vld_p1;
   logic [DOUT-1:0] r_data_p1;
   logic            r_ovf;

   assign w_q_p0    = quantise(i_din_data);
   assign w_data_p0 = w_q_p0[DOUT-1:0];
   assign w_ovf_p0  = w_q_p0[DOUT];

   // ---- p0 -> p1 : output register stage ----
`ifdef QROUND_SKID_EN
   logic            r_rdy;
   logic            r_skid_vld_p1;
   logic [DOUT-1:0] r_skid_data_p1;
   logic            w_load;
   logic            w_skid_nxt;

   assign o_din_ready = r_rdy;
   assign w_acc       = i_din_valid & r_rdy;
   assign w_load      = ~r_vld_p1 | i_dout_ready;
   assign w_skid_nxt  = ~w_load & (r_skid_vld_p1 | w_acc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdy          <= 1'b0;
         r_vld_p1       <= 1'b0;
         r_data_p1      <= '0;
         r_skid_vld_p1  <= 1'b0;
         r_skid_data_p1 <= '0;
      end else begin
         r_rdy         <= ~w_skid_nxt;
         r_skid_vld_p1 <= w_skid_nxt;
         if (w_load) begin
            if (r_skid_vld_p1) begin
               r_vld_p1  <= 1'b1;
               r_data_p1 <= r_skid_data_p1;
            end else if (w_acc) begin
               r_vld_p1  <= 1'b1;
               r_data_p1 <= w_data_p0;
            end else begin
               r_vld_p1  <= 1'b0;
            end
         end else if (w_acc) begin
            r_skid_data_p1 <= w_data_p0;
         end
      end
   end
`else
   logic r_init;

   assign o_din_ready = r_init & (i_dout_ready | ~r_vld_p1);
   assign w_acc       = i_din_valid & o_din_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_init    <= 1'b0;
         r_vld_p1  <= 1'b0;
         r_data_p1 <= '0;
      end else begin
         r_init <= 1'b1;
         if (w_acc) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_data_p0;
         end else if (i_dout_ready) begin
            r_vld_p1  <= 1'b0;
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_acc & w_ovf_p0) begin
         r_ovf <= 1'b1;
      end
   end

   assign o_dout_valid = r_vld_p1;
   assign o_dout_data  = r_data_p1;
   assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_qround.sv
// Bench for qround: eight configurations share one stimulus stream; a negedge monitor
// checks each output against an arithmetic rounding model through per-instance queues.
module tb_qround;

   localparam int NI = 8;
`ifdef QROUND_SKID_EN
   localparam int BP_EXP = 2;
`else
   localparam int BP_EXP = 1;
`endif

   function automatic int cf_nb(input int k);
      return (k == 6) ? 0 : ((k == 7) ? 1 : 4);
   endfunction
   function automatic int cf_mode(input int k);
      case (k)
         0:       return 0;
         2, 5, 7: return 2;
         default: return 1;
      endcase
   endfunction
   function automatic int cf_sg(input int k);
      return (k == 4 || k == 5 || k == 7) ? 1 : 0;
   endfunction
   function automatic int cf_sat(input int k);
      return (k == 3 || k == 5) ? 0 : 1;
   endfunction

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din_valid = 1'b0;
   logic [15:0] din_data = 16'h0;
   logic dout_ready = 1'b1;
   logic [NI-1:0] w_dr;
   logic [NI-1:0] w_dv;
   logic [NI-1:0] w_ovf;
   logic [NI-1:0][15:0] w_dd;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int NB = cf_nb(g);
      logic [15-NB:0] dq;
      qround #(.DIN(16), .NBITS(NB), .MODE(cf_mode(g)), .SIGNED(cf_sg(g)), .SAT(cf_sat(g))) u_dut (
         .clk(clk), .rst(rst),
         .i_din_valid(din_valid), .o_din_ready(w_dr[g]), .i_din_data(din_data),
         .o_dout_valid(w_dv[g]), .i_dout_ready(dout_ready), .o_dout_data(dq),
         .o_ovf(w_ovf[g]));
      assign w_dd[g] = 16'(dq);
   end

   // Reference: floor-divide by 2^nb, decide the increment from the discarded fraction
   // against one half, then range-check against the output format.
   function automatic logic [16:0] model(input logic [15:0] d, input int k);
      int nb;
      longint v, hi, frac, dv, r, mx, span;
      bit inc, o;
      nb   = cf_nb(k);
      dv   = longint'(1) << nb;
      span = longint'(1) << (16 - nb);
      v    = (cf_sg(k) != 0) ? longint'($signed(d)) : longint'({48'd0, d});
      hi   = v >>> nb;
      frac = v - hi * dv;
      case (cf_mode(k))
         1:       inc = (nb > 0) && (2 * frac >= dv);
         2:       inc = (nb > 0) && ((2 * frac > dv) || ((2 * frac == dv) && (hi % 2 != 0)));
         default: inc = 1'b0;
      endcase
      r  = hi + longint'(inc);
      mx = (cf_sg(k) != 0) ? (span / 2 - 1) : (span - 1);
      o  = (r > mx);
      if (o && cf_sat(k) != 0) r = mx;
      return {o, 16'(r & (span - 1))};
   endfunction

   logic [15:0] sb_q [NI][$];
   bit          exp_ovf [NI];
   bit          held [NI];
   logic [15:0] hold_d [NI];
   int errors = 0;
   int checks = 0;
   int ph = 0;
   int prev_ph = 0;
   int tmo = 0;
   int b_acc = 0, b_pop = 0, bp_acc = 0;
   bit rst_d1 = 1'b1, rst_d2 = 1'b1;
   logic [16:0] m_res;
   logic [15:0] e_val;

   task automatic chk(input bit ok, input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (ph != prev_ph) begin
         if (ph == 1) begin b_acc = 0; b_pop = 0; end
         if (ph == 3) bp_acc = 0;
      end
      prev_ph = ph;
      if (rst) begin
         for (int k = 0; k < NI; k++) begin
            sb_q[k].delete();
            exp_ovf[k] = 1'b0;
            held[k]    = 1'b0;
            chk(w_dv[k] == 1'b0, "rst_valid", 16'(w_dv[k]), 16'h0);
            chk(w_ovf[k] == 1'b0, "rst_ovf", 16'(w_ovf[k]), 16'h0);
            chk(w_dr[k] == 1'b0, "rst_ready", 16'(w_dr[k]), 16'h0);
            chk(w_dd[k] == 16'h0, "rst_data", w_dd[k], 16'h0);
         end
      end else begin
         if (ph == 1) begin
            if (b_acc > b_pop) chk(w_dv[0] == 1'b1, "burst_gap", 16'(w_dv[0]), 16'h1);
            if (din_valid) chk(w_dr[0] == 1'b1, "burst_ready", 16'(w_dr[0]), 16'h1);
         end
         if (ph == 2) begin
            chk(b_acc == 16, "burst_accepts", 16'(b_acc), 16'd16);
            chk(b_pop == 16, "burst_outputs", 16'(b_pop), 16'd16);
         end
         if (ph == 4) begin
            chk(bp_acc == BP_EXP, "bp_accepted", 16'(bp_acc), 16'(BP_EXP));
            chk(w_dr[0] == 1'b0, "bp_ready_low", 16'(w_dr[0]), 16'h0);
         end
         for (int k = 0; k < NI; k++) begin
            if (rst_d1) chk(w_dr[k] == 1'b0, "ready_at_release", 16'(w_dr[k]), 16'h0);
            if (rst_d2 && !rst_d1) chk(w_dr[k] == 1'b1, "ready_return", 16'(w_dr[k]), 16'h1);
            chk(w_ovf[k] == exp_ovf[k], $sformatf("ovf%0d", k), 16'(w_ovf[k]), 16'(exp_ovf[k]));
            if (held[k]) chk(w_dv[k] == 1'b1 && w_dd[k] == hold_d[k], $sformatf("stall_stable%0d", k), w_dd[k], hold_d[k]);
            if (w_dv[k] && dout_ready) begin
               held[k] = 1'b0;
               if (sb_q[k].size() == 0) begin
                  chk(1'b0, $sformatf("unexpected_out%0d", k), w_dd[k], 16'h0);
               end else begin
                  e_val = sb_q[k].pop_front();
                  chk(w_dd[k] == e_val, $sformatf("data%0d", k), w_dd[k], e_val);
               end
               if (k == 0) b_pop++;
            end else begin
               held[k]   = w_dv[k];
               hold_d[k] = w_dd[k];
            end
            if (din_valid && w_dr[k]) begin
               m_res = model(din_data, k);
               sb_q[k].push_back(m_res[15:0]);
               if (m_res[16]) exp_ovf[k] = 1'b1;
               if (k == 0) begin b_acc++; bp_acc++; end
            end
         end
         if (ph == 9) begin
            for (int k = 0; k < NI; k++)
               chk(sb_q[k].size() == 0, $sformatf("drain%0d", k), 16'(sb_q[k].size()), 16'h0);
            chk(tmo == 0, "send_timeouts", 16'(tmo), 16'h0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      end
      rst_d2 = rst_d1;
      rst_d1 = rst;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input bit rnd);
      int n;
      n = 0;
      din_valid = 1'b1;
      din_data  = d;
      forever begin
         if (rnd) dout_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (w_dr[0]) break;
         n++;
         if (n > 200) begin
            $display("FAIL send_timeout: word 0x%0h not accepted", d);
            tmo++;
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   task automatic drain();
      dout_ready = 1'b1;
      din_valid  = 1'b0;
      repeat (4) cyc();
   endtask

   logic [15:0] dir_tbl [12] = '{16'h1238, 16'h1237, 16'h1228, 16'h1229, 16'h8008, 16'h0000,
                                 16'h0018, 16'h0008, 16'hFFF8, 16'h7FF8, 16'hFFFF, 16'h1221};

   initial begin
      logic [15:0] d;
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      repeat (2) cyc();

      foreach (dir_tbl[i]) send(dir_tbl[i], 1'b0);
      drain();

      ph = 1;
      for (int i = 0; i < 16; i++) send(16'($urandom), 1'b0);
      cyc();
      ph = 2;
      cyc();
      ph = 0;
      drain();

      dout_ready = 1'b0;
      ph = 3;
      fork
         begin
            for (int i = 0; i < 4; i++) send(16'h1238 + 16'(i * 16'h0111), 1'b0);
         end
         begin
            repeat (5) cyc();
            ph = 4;
            cyc();
            ph = 0;
            dout_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               dout_ready = ($urandom_range(0, 1) != 0);
               cyc();
            end
         end
         case ($urandom_range(0, 3))
            0:       d = {12'hFFF, 4'($urandom)};
            1:       d = {12'h7FF, 4'($urandom)};
            default: d = 16'($urandom);
         endcase
         send(d, 1'b1);
      end
      drain();

      dout_ready = 1'b0;
      din_valid  = 1'b1;
      din_data   = 16'hFFF8;
      cyc();
      din_data   = 16'h7FF8;
      cyc();
      rst        = 1'b1;
      din_valid  = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      dout_ready = 1'b1;
      send(16'h0010, 1'b0);
      drain();

      for (int i = 0; i < 20; i++) send(16'($urandom), 1'b1);
      drain();

      ph = 9;
      repeat (50) cyc();
      $display("FAIL final: monitor never reached the summary");
      $fatal(1, "bench did not finish");
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
